// File: rtl/hi_score_keeper.sv
// High-score keeper: captures the score at game over, compares it digit by digit
// against the stored best, then shows the best for SHOW_TICKS game ticks.
// Optional HISCORE_BLINK_EN makes the display blink during a new-record show window.
module hi_score_keeper #(
  parameter int SHOW_TICKS = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_start,
  input  logic        game_over,
  input  logic        game_tick,
  input  logic [15:0] score,
  output logic [15:0] hi_score,
  output logic        new_record,
  output logic [15:0] display_score,
  output logic        display_blank
);

  typedef enum logic [1:0] {IDLE, COMPARE, SHOW} state_e;

  localparam logic [6:0] LAST_TICK = 7'(SHOW_TICKS - 1);

  state_e      state_q, state_d;
  logic [15:0] hi_score_q, hi_score_d;
  logic        new_record_q, new_record_d;
  logic [15:0] capture_q, capture_d;
  logic [1:0]  idx_q, idx_d;
  logic [6:0]  tick_q, tick_d;
  logic [3:0]  cap_digit, hi_digit;

  assign cap_digit = capture_q[{idx_q, 2'b00} +: 4];
  assign hi_digit  = hi_score_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    hi_score_d   = hi_score_q;
    new_record_d = new_record_q;
    capture_d    = capture_q;
    idx_d        = idx_q;
    tick_d       = tick_q;

    case (state_q)
      IDLE: begin
        if (game_over && !game_start) begin
          capture_d = score;
          idx_d     = 2'd3;
          state_d   = COMPARE;
        end
      end
      COMPARE: begin
        if (cap_digit > hi_digit) begin
          hi_score_d   = capture_q;
          new_record_d = 1'b1;
          tick_d       = '0;
          state_d      = SHOW;
        end else if (cap_digit < hi_digit || idx_q == 2'd0) begin
          tick_d  = '0;
          state_d = SHOW;
        end else begin
          idx_d = idx_q - 2'd1;
        end
      end
      SHOW: begin
        if (game_tick) begin
          if (tick_q == LAST_TICK) state_d = IDLE;
          else                     tick_d  = tick_q + 7'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new game overrides whatever is in progress, including a pending compare.
    if (game_start) begin
      state_d      = IDLE;
      new_record_d = 1'b0;
      tick_d       = '0;
      idx_d        = 2'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hi_score_q   <= 16'h0000;
      new_record_q <= 1'b0;
      capture_q    <= 16'h0000;
      idx_q        <= 2'd3;
      tick_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      hi_score_q   <= hi_score_d;
      new_record_q <= new_record_d;
      capture_q    <= capture_d;
      idx_q        <= idx_d;
      tick_q       <= tick_d;
    end
  end

  assign hi_score      = hi_score_q;
  assign new_record    = new_record_q;
  assign display_score = (state_q == SHOW) ? hi_score_q : score;

`ifdef HISCORE_BLINK_EN
  logic [3:0] blink_cnt_q, blink_cnt_d;
  logic       blank_q, blank_d;

  // Phase counter wraps every 15 ticks; blank toggles at each wrap.
  always_comb begin
    blink_cnt_d = '0;
    blank_d     = 1'b0;
    if (state_q == SHOW && state_d == SHOW) begin
      blink_cnt_d = blink_cnt_q;
      blank_d     = blank_q;
      if (game_tick) begin
        if (blink_cnt_q == 4'd14) begin
          blink_cnt_d = '0;
          blank_d     = ~blank_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 4'd1;
        end
      end
    end
    if (!new_record_d) blank_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
    end
  end

  assign display_blank = blank_q;
`else
  assign display_blank = 1'b0;
`endif

endmodule

// File: tb/tb_hi_score_keeper.sv
// Self-checking bench for hi_score_keeper: directed scenarios plus randomized games
// checked against a score-level reference model (compare as numbers, count ticks).
module tb_hi_score_keeper;

  localparam int SHOW_TICKS = 120;
  localparam logic [15:0] FILLER = 16'hBEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        game_start, game_over, game_tick;
  logic [15:0] score;
  logic [15:0] hi_score, display_score;
  logic        new_record, display_blank;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_hi;
  logic        m_nr;

  hi_score_keeper #(.SHOW_TICKS(SHOW_TICKS)) dut (
    .clk(clk), .rst_n(rst_n), .game_start(game_start), .game_over(game_over),
    .game_tick(game_tick), .score(score), .hi_score(hi_score), .new_record(new_record),
    .display_score(display_score), .display_blank(display_blank)
  );

  always #5 clk = ~clk;

  // Cycles spent comparing: decided by the most significant differing digit, 4 on a tie.
  function automatic int model_latency(input logic [15:0] cap, input logic [15:0] hi);
    for (int d = 3; d >= 0; d--)
      if (cap[d*4 +: 4] != hi[d*4 +: 4]) return 4 - d;
    return 4;
  endfunction

  function automatic logic model_blank(input int ticks_seen);
`ifdef HISCORE_BLINK_EN
    return m_nr && (((ticks_seen / 15) % 2) == 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int d = 0; d < 4; d++) v[d*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plays one game ending with score cap; checks the compare latency and the result.
  task automatic run_game(input logic [15:0] cap, input string name);
    int lat;
    lat = model_latency(cap, m_hi);
    score = cap; game_over = 1'b1;
    step();
    game_over = 1'b0; score = FILLER;
    for (int k = 1; k < lat; k++) begin
      step();
      n_checks++;
      if ({hi_score, new_record, display_score, display_blank} !== {m_hi, m_nr, FILLER, 1'b0}) begin
        n_fail++;
        $display("FAIL %s compare cycle %0d: hi=%h nr=%b disp=%h blank=%b, expected hi=%h nr=%b disp=%h blank=0",
                 name, k, hi_score, new_record, display_score, display_blank, m_hi, m_nr, FILLER);
      end
    end
    step();
    if (cap > m_hi) begin
      m_hi = cap;
      m_nr = 1'b1;
    end
    n_checks++;
    if ({hi_score, new_record, display_score, display_blank} !== {m_hi, m_nr, m_hi, 1'b0}) begin
      n_fail++;
      $display("FAIL %s decide (latency %0d): hi=%h nr=%b disp=%h blank=%b, expected hi=%h nr=%b disp=%h blank=0",
               name, lat, hi_score, new_record, display_score, display_blank, m_hi, m_nr, m_hi);
    end
  endtask

  task automatic exit_start(input string name);
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    m_nr = 1'b0;
    n_checks++;
    if ({hi_score, new_record, display_score, display_blank} !== {m_hi, 1'b0, score, 1'b0}) begin
      n_fail++;
      $display("FAIL %s start: hi=%h nr=%b disp=%h blank=%b, expected hi=%h nr=0 disp=%h blank=0",
               name, hi_score, new_record, display_score, display_blank, m_hi, score);
    end
  endtask

  // Issues n ticks from SHOW entry, with random idle gaps carrying ignored game_over pulses.
  task automatic run_ticks(input int n, input string name);
    logic [15:0] e_disp;
    logic        e_blank;
    for (int t = 1; t <= n; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        game_over = 1'($urandom_range(0, 1)); score = 16'h9999;
        step();
        game_over = 1'b0; score = FILLER;
        e_blank = model_blank(t - 1);
        n_checks++;
        if ({hi_score, new_record, display_score, display_blank} !== {m_hi, m_nr, m_hi, e_blank}) begin
          n_fail++;
          $display("FAIL %s gap before tick %0d: hi=%h nr=%b disp=%h blank=%b, expected hi=%h nr=%b disp=%h blank=%b",
                   name, t, hi_score, new_record, display_score, display_blank, m_hi, m_nr, m_hi, e_blank);
        end
      end
      game_tick = 1'b1;
      step();
      game_tick = 1'b0;
      e_disp  = (t == SHOW_TICKS) ? score : m_hi;
      e_blank = (t == SHOW_TICKS) ? 1'b0 : model_blank(t);
      n_checks++;
      if ({hi_score, new_record, display_score, display_blank} !== {m_hi, m_nr, e_disp, e_blank}) begin
        n_fail++;
        $display("FAIL %s tick %0d: hi=%h nr=%b disp=%h blank=%b, expected hi=%h nr=%b disp=%h blank=%b",
                 name, t, hi_score, new_record, display_score, display_blank, m_hi, m_nr, e_disp, e_blank);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; game_start = 1'b0; game_over = 1'b0; game_tick = 1'b0; score = 16'h1234;
    m_hi = 16'h0000; m_nr = 1'b0;
    step(); step();
    n_checks++;
    if ({hi_score, new_record, display_score, display_blank} !== {16'h0000, 1'b0, 16'h1234, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: hi=%h nr=%b disp=%h blank=%b, expected hi=0000 nr=0 disp=1234 blank=0",
               hi_score, new_record, display_score, display_blank);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_first_record();
    run_game(16'h0123, "first_record");
    exit_start("first_record");
  endtask

  task automatic test_less();
    run_game(16'h0456, "set_0456");
    exit_start("set_0456");
    run_game(16'h0455, "less_0455");
    exit_start("less_0455");
  endtask

  task automatic test_tie_and_show();
    run_game(16'h0456, "tie_0456");
    run_ticks(SHOW_TICKS, "tie_show");
  endtask

  task automatic test_start_abort();
    score = 16'h0457; game_over = 1'b1;
    step();
    game_over = 1'b0; score = FILLER;
    step();
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    m_nr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if ({hi_score, new_record, display_score} !== {m_hi, 1'b0, FILLER}) begin
        n_fail++;
        $display("FAIL abort cycle %0d: hi=%h nr=%b disp=%h, expected hi=%h nr=0 disp=%h",
                 k, hi_score, new_record, display_score, m_hi, FILLER);
      end
      step();
    end
    score = 16'h0999; game_over = 1'b1; game_start = 1'b1;
    step();
    game_over = 1'b0; game_start = 1'b0; score = FILLER;
    repeat (4) step();
    n_checks++;
    if ({hi_score, new_record, display_score} !== {m_hi, 1'b0, FILLER}) begin
      n_fail++;
      $display("FAIL same_cycle: hi=%h nr=%b disp=%h, expected hi=%h nr=0 disp=%h",
               hi_score, new_record, display_score, m_hi, FILLER);
    end
  endtask

  task automatic test_async_reset();
    run_game(16'h0999, "pre_reset_0999");
    #3 rst_n = 1'b0;
    #1;
    m_hi = 16'h0000; m_nr = 1'b0;
    n_checks++;
    if ({hi_score, new_record, display_score, display_blank} !== {16'h0000, 1'b0, FILLER, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: hi=%h nr=%b disp=%h blank=%b, expected hi=0000 nr=0 disp=%h blank=0",
               hi_score, new_record, display_score, display_blank, FILLER);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_blink();
    run_game(16'h5000, "blink_record");
    run_ticks(SHOW_TICKS, "blink_record_show");
    exit_start("blink_clear");
    run_game(16'h0100, "blink_no_record");
    run_ticks(40, "blink_no_record_show");
    exit_start("blink_no_record");
  endtask

  task automatic test_random();
    logic [15:0] cap;
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        cap = rand_bcd();
      end else begin
        cap = m_hi;
        cap[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(0, 9));
      end
      run_game(cap, $sformatf("random_%0d", i));
      if ($urandom_range(0, 5) == 0) run_ticks(SHOW_TICKS, $sformatf("random_show_%0d", i));
      else                           exit_start($sformatf("random_%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_first_record();
    test_less();
    test_tie_and_show();
    test_start_abort();
    test_async_reset();
    test_blink();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
